rom_page_loader: RTL and testbench
==================================

ROM_PAGE_LOADER -- requirements
Module: rom_page_loader

Interface
REQ-001 SHALL: PAGES, 8, number of mappable 16 KB download pages (1..64).
REQ-002 SHALL: ADDR_W, 23, SDRAM byte-address width; bank field is ADDR_W-14 bits.
REQ-003 SHALL: ROM_INDEX, 0, ioctl_index value this loader accepts.
REQ-004 SHALL: clk_sys  in  1  system clock; one clock, all logic on rising edge.
REQ-005 SHALL: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL: ce_ref  in  1  SDRAM slot strobe, one clk_sys wide.
REQ-007 SHALL: ioctl_download  in  1  host download active.
REQ-008 SHALL: ioctl_index  in  8  download target index.
REQ-009 SHALL: ioctl_wr  in  1  one-cycle byte-valid strobe.
REQ-010 SHALL: ioctl_addr  in  25  byte offset within download.
REQ-011 SHALL: ioctl_dout  in  8  download byte.
REQ-012 SHALL: page_map  in  PAGES*(ADDR_W-14)  bank for download page n at slice n.
REQ-013 SHALL: page_en  in  PAGES  bit n enables page n.
REQ-014 SHALL: ioctl_wait  out  1  host stall while a byte is in flight.
REQ-015 SHALL: wr  out  1  SDRAM write request.
REQ-016 SHALL: addr  out  ADDR_W  SDRAM write address.
REQ-017 SHALL: dout  out  8  SDRAM write data.
REQ-018 SHALL: active  out  1  ioctl_download & (ioctl_index==ROM_INDEX), combinational.
REQ-019 SHALL: done  out  1  one-cycle pulse at end of download.
REQ-020 SHALL: written  out  25  count of bytes written to SDRAM this download.
REQ-021 SHALL: checksum  out  16  modulo-2^16 sum of written bytes.
REQ-022 SHALL: skipped  out  1  sticky: a byte fell in an unmapped/disabled page.
REQ-023 SHALL: lost  out  1  sticky: ioctl_wr arrived while not IDLE.

Function
REQ-024 SHALL: page = ioctl_addr[24:14]; byte is mapped iff page<PAGES and page_en[page].
REQ-025 SHALL: mapped byte address = {page_map[page], ioctl_addr[13:0]}.
REQ-026 SHALL: FSM states IDLE, ARM, WRITE.
REQ-027 SHALL: IDLE + active + ioctl_wr + mapped -> latch addr/dout, ioctl_wait=1, go ARM next cycle.
REQ-028 SHALL: IDLE + active + ioctl_wr + unmapped -> no wait, no write, set skipped, stay IDLE.
REQ-029 SHALL: ARM: first ce_ref strictly after the latch cycle -> wr=1, go WRITE; a ce_ref coincident with the latch cycle does not count.
REQ-030 SHALL: WRITE: next ce_ref -> wr=0, ioctl_wait=0, written+=1, checksum+=dout, go IDLE.
REQ-031 SHALL: wr stays high for exactly one ce_ref period; addr/dout stable from latch until return to IDLE.
REQ-032 SHALL: ioctl_wr while in ARM/WRITE is ignored and sets lost.
REQ-033 SHALL: ioctl_wr while active=0 is ignored entirely.
REQ-034 SHALL: rising edge of active clears written, checksum, skipped, lost.
REQ-035 SHALL: done pulses one cycle after active falls AND FSM is IDLE; if active falls mid-byte, the byte completes and done follows its return to IDLE.
REQ-036 SHALL: written saturates at 2^25-1; checksum wraps.

Reset
REQ-037 SHALL: reset forces IDLE; ioctl_wait, wr, done, skipped, lost = 0; written, checksum = 0; addr, dout = 0.
REQ-038 SHALL: reset mid-byte abandons the write immediately (wr and ioctl_wait low next cycle, written unchanged by that byte).
REQ-039 SHALL: reset dominates all other inputs in the same cycle.

Verification
REQ-040 SHALL: PAGES=3, page_map={107h,100h,000h}, page_en=7; bytes at 0x0000,0x4000,0x8005 -> writes to 0x000000,0x400000,0x41C005; written=3.
REQ-041 SHALL: byte at 0xC000 with PAGES=3 -> no wr, ioctl_wait stays 0, skipped=1, written unchanged.
REQ-042 SHALL: ce_ref every 16 cycles, ioctl_wr coincident with ce_ref -> wr rises at following ce_ref (16 cycles later), falls 16 cycles after that; ioctl_wait high throughout.
REQ-043 SHALL: second ioctl_wr during ARM -> lost=1, only first byte written.
REQ-044 SHALL: bytes 0xFF x 300 -> checksum=0x2AD4, then active falls -> done single pulse; new download -> counters cleared.
REQ-045 SHALL: reset asserted in WRITE -> wr=0, ioctl_wait=0 next cycle, FSM IDLE, written=0.

Source files
------------

// File: rtl/rom_page_loader.sv
// ROM page loader: moves host download bytes into SDRAM through a page map.
// Each accepted byte is latched, then written during one full ce_ref slot.
module rom_page_loader #(
  parameter int unsigned PAGES     = 8,
  parameter int unsigned ADDR_W    = 23,
  parameter logic [7:0]  ROM_INDEX = 8'd0
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic                          ce_ref,
  input  logic                          ioctl_download,
  input  logic [7:0]                    ioctl_index,
  input  logic                          ioctl_wr,
  input  logic [24:0]                   ioctl_addr,
  input  logic [7:0]                    ioctl_dout,
  input  logic [PAGES*(ADDR_W-14)-1:0]  page_map,
  input  logic [PAGES-1:0]              page_en,
  output logic                          ioctl_wait,
  output logic                          wr,
  output logic [ADDR_W-1:0]             addr,
  output logic [7:0]                    dout,
  output logic                          active,
  output logic                          done,
  output logic [24:0]                   written,
  output logic [15:0]                   checksum,
  output logic                          skipped,
  output logic                          lost
);

  localparam int unsigned BW = ADDR_W - 14;

  typedef enum logic [1:0] {IDLE, ARM, WRITE} state_t;

  state_t          state, state_next;
  logic            active_q;
  logic            end_pending;
  logic [10:0]     page;
  logic            mapped;
  logic [BW-1:0]   bank;
  logic            take, drop, collide, finish, rise, fall;
  logic [24:0]     written_base, written_next;
  logic [15:0]     checksum_base, checksum_next;

  assign active  = ioctl_download & (ioctl_index == ROM_INDEX);
  assign page    = ioctl_addr[24:14];
  assign rise    = active & ~active_q;
  assign fall    = ~active & active_q;
  assign take    = (state == IDLE) & active & ioctl_wr & mapped;
  assign drop    = (state == IDLE) & active & ioctl_wr & ~mapped;
  assign collide = (state != IDLE) & active & ioctl_wr;
  assign finish  = (state == WRITE) & ce_ref;

  // Page lookup: pages at or beyond PAGES are never mapped.
  always_comb begin
    mapped = 1'b0;
    bank   = '0;
    for (int unsigned n = 0; n < PAGES; n++) begin
      if (page == 11'(n)) begin
        mapped = page_en[n];
        bank   = page_map[n*BW +: BW];
      end
    end
  end

  // Counter updates; a new download clears first, so a byte completing in the
  // same cycle is still counted against the new download.
  always_comb begin
    written_base  = rise ? '0 : written;
    checksum_base = rise ? '0 : checksum;
    written_next  = written_base;
    checksum_next = checksum_base;
    if (finish) begin
      if (written_base != '1) written_next = written_base + 25'd1;
      checksum_next = checksum_base + {8'h00, dout};
    end
  end

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    wr         = 1'b0;
    ioctl_wait = 1'b0;
    unique case (state)
      IDLE: begin
        if (take) state_next = ARM;
      end
      ARM: begin
        ioctl_wait = 1'b1;
        if (ce_ref) state_next = WRITE;
      end
      WRITE: begin
        ioctl_wait = 1'b1;
        wr         = 1'b1;
        if (ce_ref) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latched byte, statistics, sticky flags and end-of-download pulse.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      active_q    <= 1'b0;
      end_pending <= 1'b0;
      done        <= 1'b0;
      written     <= '0;
      checksum    <= '0;
      skipped     <= 1'b0;
      lost        <= 1'b0;
      addr        <= '0;
      dout        <= '0;
    end else begin
      active_q <= active;
      written  <= written_next;
      checksum <= checksum_next;
      skipped  <= (rise ? 1'b0 : skipped) | drop;
      lost     <= (rise ? 1'b0 : lost) | collide;
      if (take) begin
        addr <= {bank, ioctl_addr[13:0]};
        dout <= ioctl_dout;
      end
      done <= 1'b0;
      // A fall seen mid-byte is remembered until the FSM is back in IDLE.
      if (active) begin
        end_pending <= 1'b0;
      end else if (end_pending | fall) begin
        if (state == IDLE) begin
          done        <= 1'b1;
          end_pending <= 1'b0;
        end else begin
          end_pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rom_page_loader.sv
// Directed bench for rom_page_loader with PAGES=3 and ce_ref every 16 clocks.
module tb_rom_page_loader;

  localparam int unsigned PAGES  = 3;
  localparam int unsigned ADDR_W = 23;

  logic                          clk_sys = 1'b0;
  logic                          reset = 1'b1;
  logic                          ce_ref = 1'b0;
  logic                          ioctl_download = 1'b0;
  logic [7:0]                    ioctl_index = 8'd0;
  logic                          ioctl_wr = 1'b0;
  logic [24:0]                   ioctl_addr = '0;
  logic [7:0]                    ioctl_dout = '0;
  logic [PAGES*(ADDR_W-14)-1:0]  page_map = {9'h107, 9'h100, 9'h000};
  logic [PAGES-1:0]              page_en = 3'b111;
  logic                          ioctl_wait, wr, active, done, skipped, lost;
  logic [ADDR_W-1:0]             addr;
  logic [7:0]                    dout;
  logic [24:0]                   written;
  logic [15:0]                   checksum;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned ce_per  = 16;

  rom_page_loader #(.PAGES(PAGES), .ADDR_W(ADDR_W), .ROM_INDEX(8'd0)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_ref(ce_ref),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .page_map(page_map), .page_en(page_en),
    .ioctl_wait(ioctl_wait), .wr(wr), .addr(addr), .dout(dout),
    .active(active), .done(done), .written(written), .checksum(checksum),
    .skipped(skipped), .lost(lost)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; inputs change 1 ns after the edge, ioctl_wr is a single-cycle pulse.
  task automatic step();
    @(posedge clk_sys);
    #1;
    cyc++;
    ce_ref   = (cyc % ce_per == 0);
    ioctl_wr = 1'b0;
  endtask

  task automatic align_ce();
    int unsigned n = 0;
    while (!ce_ref && n < 64) begin
      step();
      n++;
    end
  endtask

  // Present a byte in a ce_ref cycle; returns one cycle after the latch cycle.
  task automatic put_byte(input logic [24:0] a, input logic [7:0] d);
    align_ce();
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    step();
  endtask

  // Full byte transfer with fixed ce_ref timing; timing checks when full=1.
  task automatic xfer(input logic [24:0] a, input logic [7:0] d,
                      input logic [ADDR_W-1:0] exp_addr, input bit full);
    bit arm_ok = 1'b1;
    bit hold_ok = 1'b1;
    put_byte(a, d);
    for (int i = 0; i < 15; i++) begin
      arm_ok &= (ioctl_wait === 1'b1) && (wr === 1'b0);
      step();
    end
    if (full) begin
      check("arm_wait", 32'(arm_ok), 32'd1);
      check("arm_no_wr", 32'(wr), 32'd0);
    end
    step();
    if (full) begin
      check("wr_rise", 32'(wr), 32'd1);
      check("wr_addr", 32'(addr), 32'(exp_addr));
      check("wr_dout", 32'(dout), 32'(d));
    end
    for (int i = 0; i < 16; i++) begin
      hold_ok &= (wr === 1'b1) && (ioctl_wait === 1'b1) && (addr === exp_addr) && (dout === d);
      step();
    end
    if (full) begin
      check("wr_hold", 32'(hold_ok), 32'd1);
      check("wr_fall", 32'(wr), 32'd0);
      check("wait_fall", 32'(ioctl_wait), 32'd0);
    end
  endtask

  initial begin
    bit quiet;
    bit any_done;

    // Reset state
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_wr", 32'(wr), 32'd0);
    check("rst_wait", 32'(ioctl_wait), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_written", 32'(written), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    check("rst_flags", 32'({skipped, lost}), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);

    // Active decode
    ioctl_download = 1'b1;
    ioctl_index    = 8'd1;
    #1 check("active_idx", 32'(active), 32'd0);
    ioctl_index = 8'd0;
    #1 check("active_on", 32'(active), 32'd1);
    step();

    // Mapped writes through pages 0, 1, 2
    xfer(25'h0000, 8'h11, 23'h000000, 1'b1);
    xfer(25'h4000, 8'h22, 23'h400000, 1'b1);
    xfer(25'h8005, 8'h33, 23'h41C005, 1'b1);
    check("written3", 32'(written), 32'd3);
    check("checksum3", 32'(checksum), 32'h66);

    // Second ioctl_wr during ARM is dropped and flagged
    put_byte(25'h0010, 8'h44);
    ioctl_addr = 25'h0020;
    ioctl_dout = 8'h55;
    ioctl_wr   = 1'b1;
    step();
    check("lost_set", 32'(lost), 32'd1);
    repeat (15) step();
    check("lost_wr", 32'(wr), 32'd1);
    check("lost_addr", 32'(addr), 32'h000010);
    check("lost_dout", 32'(dout), 32'h44);
    repeat (16) step();
    check("lost_written", 32'(written), 32'd4);
    check("lost_checksum", 32'(checksum), 32'hAA);
    check("done_idle", 32'(done), 32'd0);

    // Active falls while IDLE: single done pulse
    ioctl_download = 1'b0;
    step();
    check("done_pulse", 32'(done), 32'd1);
    step();
    check("done_single", 32'(done), 32'd0);

    // ioctl_wr with active low is ignored
    put_byte(25'h0000, 8'h77);
    check("inact_wait", 32'(ioctl_wait), 32'd0);
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      quiet &= (wr === 1'b0) && (ioctl_wait === 1'b0);
      step();
    end
    check("inact_quiet", 32'(quiet), 32'd1);
    check("inact_written", 32'(written), 32'd4);

    // New download clears statistics
    ioctl_download = 1'b1;
    step();
    check("clr_written", 32'(written), 32'd0);
    check("clr_checksum", 32'(checksum), 32'd0);
    check("clr_flags", 32'({skipped, lost}), 32'd0);

    // 300 bytes of 0xFF: 76500 mod 65536 = 0x2AD4
    for (int i = 0; i < 300; i++) xfer(25'(i), 8'hFF, 23'(i), 1'b0);
    check("ff_written", 32'(written), 32'd300);
    check("ff_checksum", 32'(checksum), 32'h2AD4);

    // Active falls mid-byte: byte completes, then done
    put_byte(25'h0001, 8'h01);
    ioctl_download = 1'b0;
    any_done = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      any_done |= done;
    end
    check("mid_no_early_done", 32'(any_done), 32'd0);
    check("mid_idle", 32'(ioctl_wait), 32'd0);
    check("mid_written", 32'(written), 32'd301);
    check("mid_checksum", 32'(checksum), 32'h2AD5);
    step();
    check("mid_done", 32'(done), 32'd1);
    step();
    check("mid_done_single", 32'(done), 32'd0);

    // Unmapped page (page 3 with PAGES=3)
    ioctl_download = 1'b1;
    step();
    check("clr2_written", 32'(written), 32'd0);
    put_byte(25'hC000, 8'h99);
    check("skip_wait", 32'(ioctl_wait), 32'd0);
    check("skip_flag", 32'(skipped), 32'd1);
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      quiet &= (wr === 1'b0) && (ioctl_wait === 1'b0);
      step();
    end
    check("skip_quiet", 32'(quiet), 32'd1);
    check("skip_written", 32'(written), 32'd0);

    // Disabled page in a fresh download
    ioctl_download = 1'b0;
    step();
    step();
    ioctl_download = 1'b1;
    step();
    check("clr3_skipped", 32'(skipped), 32'd0);
    page_en = 3'b101;
    put_byte(25'h4000, 8'h12);
    check("dis_wait", 32'(ioctl_wait), 32'd0);
    check("dis_skipped", 32'(skipped), 32'd1);
    page_en = 3'b111;

    // Reset during WRITE abandons the byte; reset beats a coincident ioctl_wr
    put_byte(25'h0004, 8'h5A);
    repeat (16) step();
    check("rstw_pre", 32'(wr), 32'd1);
    reset      = 1'b1;
    ioctl_addr = 25'h0008;
    ioctl_wr   = 1'b1;
    step();
    check("rstw_wr", 32'(wr), 32'd0);
    check("rstw_wait", 32'(ioctl_wait), 32'd0);
    check("rstw_written", 32'(written), 32'd0);
    check("rstw_flags", 32'({skipped, lost}), 32'd0);
    reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      quiet &= (wr === 1'b0) && (ioctl_wait === 1'b0);
    end
    check("rstw_idle", 32'(quiet), 32'd1);
    check("rstw_written2", 32'(written), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
